// File: rtl/paketleme_pkg.sv
// Shared types and default widths for the packaging scheduler
// and the single paketleme unit it drives.
package paketleme_pkg;

  localparam int PKT_KAPASITE_W = 10;
  localparam int PKT_MALIYET_W  = 3;

  typedef enum logic [2:0] {
    BOS,
    BASLAT,
    BEKLE,
    BITIR,
    BOSALT
  } durum_t;

endpackage

// File: rtl/paketleme_planlayici_rr_hakem.sv
// Combinational round-robin picker: first set request at or
// above the pointer, wrapping around.
module rr_hakem
  import paketleme_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         istek,
  input  logic [$clog2(N)-1:0] isaretci,
  output logic [N-1:0]         verme,
  output logic [$clog2(N)-1:0] indeks,
  output logic                 herhangi
);

  localparam int IW = $clog2(N);

  always_comb begin : secim
    int j;
    verme    = '0;
    indeks   = '0;
    herhangi = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(isaretci) + k;
      if (j >= N) j = j - N;
      if (!herhangi && istek[j]) begin
        herhangi = 1'b1;
        verme[j] = 1'b1;
        indeks   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/paketleme_planlayici.sv
// Shares one paketleme unit between several production lines,
// round-robin, and keeps a saturating phone total per line.
module paketleme_planlayici
  import paketleme_pkg::*;
#(
  parameter int HAT_SAYISI  = 4,
  parameter int KAPASITE_W  = PKT_KAPASITE_W,
  parameter int ZAMAN_ASIMI = 2048,
  parameter int TOPLAM_W    = 16
) (
  input  logic                           saat,
  input  logic                           reset,
  input  logic [HAT_SAYISI-1:0]          hat_istek,
  input  logic [HAT_SAYISI*KAPASITE_W-1:0] hat_kapasite,
  input  logic [HAT_SAYISI-1:0]          hat_bandrol,
  input  logic [HAT_SAYISI-1:0]          hat_kontrol,
  output logic [HAT_SAYISI-1:0]          hat_onay,
  output logic                           hat_hata,
  output logic [KAPASITE_W-1:0]          sonuc_telefon,
  output logic [PKT_MALIYET_W-1:0]       sonuc_maliyet,
  output logic [HAT_SAYISI*TOPLAM_W-1:0] hat_toplam,
  output logic                           mesgul,
  output logic                           paket_basla,
  output logic [KAPASITE_W-1:0]          paket_kapasite,
  output logic                           paket_bandrol,
  output logic                           paket_kontrol,
  input  logic                           paket_bitti,
  input  logic [PKT_MALIYET_W-1:0]       paket_maliyet,
  input  logic [KAPASITE_W-1:0]          paket_telefon
);

  localparam int IW = $clog2(HAT_SAYISI);
  localparam int SW = $clog2(ZAMAN_ASIMI);

  durum_t          durum, durum_d;
  logic [IW-1:0]   isaretci, isaretci_d;
  logic [IW-1:0]   verme_idx, verme_d;
  logic [SW-1:0]   sayac, sayac_d;

  logic                           basla_d;
  logic [KAPASITE_W-1:0]          kap_d;
  logic                           band_d;
  logic                           kont_d;
  logic [HAT_SAYISI-1:0]          onay_d;
  logic                           hata_d;
  logic [KAPASITE_W-1:0]          tel_d;
  logic [PKT_MALIYET_W-1:0]       mal_d;
  logic [HAT_SAYISI*TOPLAM_W-1:0] toplam_d;
  logic                           mesgul_d;

  logic [HAT_SAYISI-1:0] hakem_verme;
  logic [IW-1:0]         hakem_idx;
  logic                  hakem_var;

  logic [TOPLAM_W:0] ek;
  logic [TOPLAM_W:0] top_toplam;

  rr_hakem #(
    .N(HAT_SAYISI)
  ) u_hakem (
    .istek    (hat_istek),
    .isaretci (isaretci),
    .verme    (hakem_verme),
    .indeks   (hakem_idx),
    .herhangi (hakem_var)
  );

  always_comb begin
    durum_d    = durum;
    isaretci_d = isaretci;
    verme_d    = verme_idx;
    sayac_d    = sayac;
    basla_d    = paket_basla;
    kap_d      = paket_kapasite;
    band_d     = paket_bandrol;
    kont_d     = paket_kontrol;
    onay_d     = '0;
    hata_d     = hat_hata;
    tel_d      = sonuc_telefon;
    mal_d      = sonuc_maliyet;
    toplam_d   = hat_toplam;

    ek = '0;
    ek[KAPASITE_W-1:0] = sonuc_telefon;
    top_toplam = {1'b0, hat_toplam[verme_idx*TOPLAM_W +: TOPLAM_W]} + ek;

    unique case (durum)
      BOS: begin
        if (hakem_var) begin
          durum_d = BASLAT;
          verme_d = hakem_idx;
          kap_d   = hat_kapasite[hakem_idx*KAPASITE_W +: KAPASITE_W];
          band_d  = hat_bandrol[hakem_idx];
          kont_d  = hat_kontrol[hakem_idx];
          basla_d = 1'b1;
        end
      end
      BASLAT: begin
        sayac_d = '0;
        durum_d = BEKLE;
      end
      BEKLE: begin
        if (paket_bitti) begin
          tel_d             = paket_telefon;
          mal_d             = paket_maliyet;
          hata_d            = 1'b0;
          basla_d           = 1'b0;
          onay_d[verme_idx] = 1'b1;
          durum_d           = BITIR;
        end else if (sayac == SW'(ZAMAN_ASIMI - 1)) begin
          tel_d             = '0;
          mal_d             = '0;
          hata_d            = 1'b1;
          basla_d           = 1'b0;
          onay_d[verme_idx] = 1'b1;
          durum_d           = BITIR;
        end else begin
          sayac_d = sayac + SW'(1);
        end
      end
      BITIR: begin
        // Total clamps instead of wrapping so a busy line never reads low.
        if (!hat_hata) begin
          toplam_d[verme_idx*TOPLAM_W +: TOPLAM_W] =
            top_toplam[TOPLAM_W] ? '1 : top_toplam[TOPLAM_W-1:0];
        end
        isaretci_d = (verme_idx == IW'(HAT_SAYISI - 1)) ?
                     '0 : verme_idx + IW'(1);
        durum_d = BOSALT;
      end
      BOSALT: begin
        if (!paket_bitti) durum_d = BOS;
      end
      default: durum_d = BOS;
    endcase

    mesgul_d = (durum_d != BOS);
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum          <= BOS;
      isaretci       <= '0;
      verme_idx      <= '0;
      sayac          <= '0;
      paket_basla    <= 1'b0;
      paket_kapasite <= '0;
      paket_bandrol  <= 1'b0;
      paket_kontrol  <= 1'b0;
      hat_onay       <= '0;
      hat_hata       <= 1'b0;
      sonuc_telefon  <= '0;
      sonuc_maliyet  <= '0;
      hat_toplam     <= '0;
      mesgul         <= 1'b0;
    end else begin
      durum          <= durum_d;
      isaretci       <= isaretci_d;
      verme_idx      <= verme_d;
      sayac          <= sayac_d;
      paket_basla    <= basla_d;
      paket_kapasite <= kap_d;
      paket_bandrol  <= band_d;
      paket_kontrol  <= kont_d;
      hat_onay       <= onay_d;
      hat_hata       <= hata_d;
      sonuc_telefon  <= tel_d;
      sonuc_maliyet  <= mal_d;
      hat_toplam     <= toplam_d;
      mesgul         <= mesgul_d;
    end
  end

endmodule

// File: tb/tb_paketleme_planlayici.sv
// Directed bench for paketleme_planlayici: vector table for the
// round-robin order plus hand sequences for multi-cycle corners.
module tb_paketleme_planlayici;

  localparam int N  = 4;
  localparam int KW = 10;
  localparam int ZA = 2048;
  localparam int TW = 16;

  logic          saat = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  hat_istek;
  logic [N*KW-1:0] hat_kapasite;
  logic [N-1:0]  hat_bandrol;
  logic [N-1:0]  hat_kontrol;
  logic [N-1:0]  hat_onay;
  logic          hat_hata;
  logic [KW-1:0] sonuc_telefon;
  logic [2:0]    sonuc_maliyet;
  logic [N*TW-1:0] hat_toplam;
  logic          mesgul;
  logic          paket_basla;
  logic [KW-1:0] paket_kapasite;
  logic          paket_bandrol;
  logic          paket_kontrol;
  logic          paket_bitti;
  logic [2:0]    paket_maliyet;
  logic [KW-1:0] paket_telefon;

  int gecen = 0;
  int sayi  = 0;

  always #5 saat = ~saat;

  paketleme_planlayici #(
    .HAT_SAYISI  (N),
    .KAPASITE_W  (KW),
    .ZAMAN_ASIMI (ZA),
    .TOPLAM_W    (TW)
  ) dut (
    .saat           (saat),
    .reset          (reset),
    .hat_istek      (hat_istek),
    .hat_kapasite   (hat_kapasite),
    .hat_bandrol    (hat_bandrol),
    .hat_kontrol    (hat_kontrol),
    .hat_onay       (hat_onay),
    .hat_hata       (hat_hata),
    .sonuc_telefon  (sonuc_telefon),
    .sonuc_maliyet  (sonuc_maliyet),
    .hat_toplam     (hat_toplam),
    .mesgul         (mesgul),
    .paket_basla    (paket_basla),
    .paket_kapasite (paket_kapasite),
    .paket_bandrol  (paket_bandrol),
    .paket_kontrol  (paket_kontrol),
    .paket_bitti    (paket_bitti),
    .paket_maliyet  (paket_maliyet),
    .paket_telefon  (paket_telefon)
  );

  typedef struct {
    logic [3:0]  istek;
    logic [9:0]  tel;
    logic [2:0]  mal;
    logic [3:0]  onay;
    logic [9:0]  kap;
    logic [1:0]  bk;
    int          hat;
    logic [15:0] tpl;
  } vek_t;

  vek_t tablo[9];

  task automatic kontrol(input string ad, input logic [63:0] g,
                         input logic [63:0] b);
    sayi++;
    if (g === b) gecen++;
    else $display("FAIL %s: got %0d expected %0d", ad, g, b);
  endtask

  function automatic logic [TW-1:0] tpl(input int i);
    return hat_toplam[i*TW +: TW];
  endfunction

  // Waits for a grant, plays the unit answering after one BEKLE
  // cycle, then holds bitti for 'tut' extra cycles.
  task automatic is_calis(input logic [9:0] tel, input logic [2:0] mal,
                          input int tut,
                          output logic [3:0] onay, output logic [9:0] kap,
                          output logic [1:0] bk, output logic [9:0] s_tel,
                          output logic [2:0] s_mal, output logic hata,
                          output int basla_tut);
    int n;
    onay = '0; kap = '0; bk = '0; s_tel = '0; s_mal = '0;
    hata = 1'b0; basla_tut = 0;
    n = 0;
    while (!paket_basla && n < 20) begin
      @(negedge saat);
      n++;
    end
    kontrol("basla_geldi", paket_basla, 1);
    if (!paket_basla) return;
    kap = paket_kapasite;
    bk  = {paket_bandrol, paket_kontrol};
    @(negedge saat);
    paket_bitti = 1'b1;
    paket_telefon = tel;
    paket_maliyet = mal;
    n = 0;
    do begin
      @(negedge saat);
      n++;
    end while (hat_onay == '0 && n < 20);
    kontrol("onay_geldi", hat_onay != '0, 1);
    onay  = hat_onay;
    s_tel = sonuc_telefon;
    s_mal = sonuc_maliyet;
    hata  = hat_hata;
    for (int k = 0; k < tut; k++) begin
      @(negedge saat);
      if (paket_basla || hat_onay != '0) basla_tut++;
    end
    paket_bitti = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] onay;
    logic [9:0] kap;
    logic [1:0] bk;
    logic [9:0] st;
    logic [2:0] sm;
    logic       h;
    int         bt;
    int         c;

    tablo[0] = '{4'b1111, 10'd3,  3'd1, 4'b0001, 10'd8,  2'b11, 0, 16'd3};
    tablo[1] = '{4'b1111, 10'd4,  3'd2, 4'b0010, 10'd17, 2'b01, 1, 16'd4};
    tablo[2] = '{4'b1111, 10'd7,  3'd3, 4'b0100, 10'd26, 2'b10, 2, 16'd7};
    tablo[3] = '{4'b1111, 10'd9,  3'd4, 4'b1000, 10'd35, 2'b00, 3, 16'd9};
    tablo[4] = '{4'b1011, 10'd2,  3'd5, 4'b0001, 10'd40, 2'b11, 0, 16'd5};
    tablo[5] = '{4'b1101, 10'd10, 3'd6, 4'b0100, 10'd50, 2'b10, 2, 16'd17};
    tablo[6] = '{4'b1001, 10'd1,  3'd7, 4'b1000, 10'd59, 2'b00, 3, 16'd10};
    tablo[7] = '{4'b0011, 10'd6,  3'd0, 4'b0001, 10'd64, 2'b11, 0, 16'd11};
    tablo[8] = '{4'b0011, 10'd20, 3'd3, 4'b0010, 10'd73, 2'b01, 1, 16'd24};

    hat_istek = '0; hat_kapasite = '0; hat_bandrol = '0; hat_kontrol = '0;
    paket_bitti = 1'b0; paket_telefon = '0; paket_maliyet = '0;
    repeat (3) @(negedge saat);

    kontrol("rst_basla", paket_basla, 0);
    kontrol("rst_mesgul", mesgul, 0);
    kontrol("rst_onay", hat_onay, 0);
    kontrol("rst_toplam", hat_toplam, 0);
    kontrol("rst_kap", paket_kapasite, 0);
    kontrol("rst_tel", sonuc_telefon, 0);
    reset = 1'b1;
    @(negedge saat);

    // single request on line 2
    hat_istek = 4'b0100;
    hat_kapasite[2*KW +: KW] = 10'd81;
    hat_bandrol = 4'b0100;
    hat_kontrol = 4'b0100;
    @(negedge saat);
    kontrol("tek_basla", paket_basla, 1);
    kontrol("tek_mesgul", mesgul, 1);
    kontrol("tek_kap", paket_kapasite, 81);
    kontrol("tek_bk", {paket_bandrol, paket_kontrol}, 2'b11);
    hat_istek = '0;
    hat_kapasite[2*KW +: KW] = 10'd300;
    @(negedge saat);
    kontrol("tek_bekle_basla", paket_basla, 1);
    kontrol("tek_kap_tut", paket_kapasite, 81);
    paket_bitti = 1'b1; paket_telefon = 10'd5; paket_maliyet = 3'd6;
    @(negedge saat);
    kontrol("tek_onay", hat_onay, 4'b0100);
    kontrol("tek_tel", sonuc_telefon, 5);
    kontrol("tek_mal", sonuc_maliyet, 6);
    kontrol("tek_hata", hat_hata, 0);
    kontrol("tek_basla_dus", paket_basla, 0);
    paket_bitti = 1'b0;
    @(negedge saat);
    kontrol("tek_onay_tek", hat_onay, 0);
    kontrol("tek_toplam", tpl(2), 5);
    kontrol("tek_tel_tut", sonuc_telefon, 5);
    kontrol("tek_bosalt_mesgul", mesgul, 1);
    @(negedge saat);
    kontrol("tek_bos_mesgul", mesgul, 0);

    reset = 1'b0;
    @(negedge saat);
    reset = 1'b1;
    hat_bandrol = 4'b0101;
    hat_kontrol = 4'b0011;

    for (int r = 0; r < 9; r++) begin
      hat_istek = tablo[r].istek;
      for (int i = 0; i < N; i++)
        hat_kapasite[i*KW +: KW] = KW'((r + 1) * 8 + i);
      is_calis(tablo[r].tel, tablo[r].mal, 0, onay, kap, bk, st, sm, h, bt);
      kontrol($sformatf("v%0d_onay", r), onay, tablo[r].onay);
      kontrol($sformatf("v%0d_kap", r), kap, tablo[r].kap);
      kontrol($sformatf("v%0d_bk", r), bk, tablo[r].bk);
      kontrol($sformatf("v%0d_tel", r), st, tablo[r].tel);
      kontrol($sformatf("v%0d_mal", r), sm, tablo[r].mal);
      kontrol($sformatf("v%0d_hata", r), h, 0);
      @(negedge saat);
      kontrol($sformatf("v%0d_toplam", r), tpl(tablo[r].hat), tablo[r].tpl);
    end
    hat_istek = '0;

    // timeout on line 1, unit silent but presenting junk data
    @(negedge saat);
    hat_istek = 4'b0010;
    paket_telefon = 10'd50;
    paket_maliyet = 3'd5;
    c = 0;
    while (!paket_basla && c < 20) begin
      @(negedge saat);
      c++;
    end
    kontrol("tmo_basla", paket_basla, 1);
    hat_istek = '0;
    c = 0;
    do begin
      @(negedge saat);
      c++;
    end while (hat_onay == '0 && c < 3000);
    kontrol("tmo_sure", c, ZA + 1);
    kontrol("tmo_onay", hat_onay, 4'b0010);
    kontrol("tmo_hata", hat_hata, 1);
    kontrol("tmo_tel", sonuc_telefon, 0);
    kontrol("tmo_mal", sonuc_maliyet, 0);
    @(negedge saat);
    kontrol("tmo_toplam", tpl(1), 24);

    // stuck bitti on line 3
    hat_istek = 4'b1000;
    is_calis(10'd5, 3'd2, 10, onay, kap, bk, st, sm, h, bt);
    kontrol("tak_onay", onay, 4'b1000);
    kontrol("tak_yeni_verme", bt, 0);
    kontrol("tak_toplam", tpl(3), 15);
    hat_istek = 4'b0001;
    c = 0;
    while (!paket_basla && c < 20) begin
      @(negedge saat);
      c++;
    end
    kontrol("tak_sonra_gecikme", c, 2);
    is_calis(10'd0, 3'd1, 0, onay, kap, bk, st, sm, h, bt);
    kontrol("tak_sonra_onay", onay, 4'b0001);

    // saturation on line 1
    hat_istek = 4'b0010;
    for (int k = 0; k < 66; k++) begin
      is_calis(10'd1023, 3'd1, 0, onay, kap, bk, st, sm, h, bt);
      if (k == 63) begin
        @(negedge saat);
        kontrol("doy_64", tpl(1), 65496);
      end
    end
    kontrol("doy_onay", onay, 4'b0010);
    @(negedge saat);
    kontrol("doy_sinir", tpl(1), 65535);
    hat_istek = '0;

    // reset in the middle of BEKLE on line 2
    @(negedge saat);
    hat_istek = 4'b0100;
    c = 0;
    while (!paket_basla && c < 20) begin
      @(negedge saat);
      c++;
    end
    kontrol("rb_basla", paket_basla, 1);
    hat_istek = '0;
    repeat (2) @(negedge saat);
    reset = 1'b0;
    #1;
    kontrol("rb_basla_dus", paket_basla, 0);
    kontrol("rb_mesgul", mesgul, 0);
    kontrol("rb_toplam", hat_toplam, 0);
    kontrol("rb_kap", paket_kapasite, 0);
    @(negedge saat);
    kontrol("rb_onay_yok", hat_onay, 0);
    hat_istek = 4'b0110;
    reset = 1'b1;
    is_calis(10'd7, 3'd2, 0, onay, kap, bk, st, sm, h, bt);
    kontrol("rb_sonra_onay", onay, 4'b0010);
    hat_istek = '0;
    @(negedge saat);
    kontrol("rb_sonra_toplam1", tpl(1), 7);
    kontrol("rb_sonra_toplam2", tpl(2), 0);
    repeat (2) @(negedge saat);

    $display("%0d/%0d checks passed", gecen, sayi);
    $finish;
  end

endmodule
